// File: rtl/ledmatrix_pwm_scan.sv
// ---------------------------------------------------------------------------
// ledmatrix_pwm_scan
//
// Multiplexed LED-matrix scanner with per-pixel PWM grayscale and a
// double-buffered frame store. One column is driven at a time. Each column
// is shown for SLOTS = 2^BPP-1 PWM slots of DWELL clocks each, followed by
// BLANK clocks with every line off. A row is lit in a slot when its pixel
// value is greater than the slot number, so the value 0 is always dark and
// the value 2^BPP-1 is lit in every slot.
//
// New frames are written into a pending buffer. The pending buffer moves
// into the displayed buffer only on the last blank cycle of the last column,
// so a frame is never shown half old and half new.
//
// Outputs are logical drives (row r, column c), not PMOD pin order.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   frame_data   new frame; pixel (c,r) at bits [(c*ROWS+r)*BPP +: BPP]
//   frame_wr     one-cycle strobe, captures frame_data into the pending buffer
//   row_out      registered row drive (polarity from ROW_ACTIVE_HIGH)
//   col_out      registered column select (polarity from COL_ACTIVE_LOW)
//   col_idx      column whose drive is on the outputs (held during blank)
//   frame_start  high on the first cycle column 0 slot 0 is driven
//   swapped      high on the cycle the displayed buffer takes pending data
//   pending      pending buffer holds a frame that is not yet displayed
// ---------------------------------------------------------------------------
module ledmatrix_pwm_scan #(
  parameter int ROWS            = 8,
  parameter int COLS            = 8,
  parameter int BPP             = 4,
  parameter int DWELL           = 1,
  parameter int BLANK           = 1,
  parameter bit COL_ACTIVE_LOW  = 1'b1,
  parameter bit ROW_ACTIVE_HIGH = 1'b1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [ROWS*COLS*BPP-1:0]                    frame_data,
  input  logic                                        frame_wr,
  output logic [ROWS-1:0]                             row_out,
  output logic [COLS-1:0]                             col_out,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0]  col_idx,
  output logic                                        frame_start,
  output logic                                        swapped,
  output logic                                        pending
);

  localparam int SLOTS    = (1 << BPP) - 1;
  localparam int PIX_W    = ROWS * COLS * BPP;
  localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int TICK_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  localparam logic [BPP-1:0]    SLOT_LAST  = BPP'(SLOTS - 1);
  localparam logic [TICK_W-1:0] DWELL_LAST = TICK_W'(DWELL - 1);
  localparam logic [TICK_W-1:0] BLANK_LAST = TICK_W'(BLANK - 1);
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(COLS - 1);

  // Inactive levels for the line drives.
  localparam logic [ROWS-1:0] ROWS_OFF = {ROWS{~ROW_ACTIVE_HIGH}};
  localparam logic [COLS-1:0] COLS_OFF = {COLS{COL_ACTIVE_LOW}};

  typedef enum logic {
    S_DRIVE = 1'b0,
    S_BLANK = 1'b1
  } scan_state_t;

  // Scan position. These registers always describe the drive that is
  // currently on the outputs, so status flags can be decoded from them
  // directly without extra pipeline alignment.
  scan_state_t       state, state_n;
  logic [COL_W-1:0]  col, col_n;
  logic [BPP-1:0]    slot, slot_n;
  logic [TICK_W-1:0] tick, tick_n;
  logic              started;

  // Frame buffers.
  logic [PIX_W-1:0]  active, active_n;
  logic [PIX_W-1:0]  pend;
  logic              pending_q;

  logic              frame_end;
  logic              do_swap;

  logic [ROWS-1:0]   row_n;
  logic [COLS-1:0]   col_sel_n;

  // Frame end is the final blank cycle of the last column; the swap happens
  // at the edge that closes it so the next column 0 already shows new data.
  assign frame_end = started && (state == S_BLANK) && (tick == BLANK_LAST) &&
                     (col == COL_LAST);
  assign do_swap   = frame_end && pending_q;
  assign active_n  = do_swap ? pend : active;

  assign col_idx     = col;
  assign pending     = pending_q;
  assign swapped     = do_swap;
  assign frame_start = started && (state == S_DRIVE) && (col == '0) &&
                       (slot == '0) && (tick == '0);

  // Scan state register. Reset parks the counters at column 0 and clears
  // 'started', so the first edge after reset begins a fresh frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_DRIVE;
      col     <= '0;
      slot    <= '0;
      tick    <= '0;
      started <= 1'b0;
    end else begin
      state   <= state_n;
      col     <= col_n;
      slot    <= slot_n;
      tick    <= tick_n;
      started <= 1'b1;
    end
  end

  // Next scan position. In drive, tick counts DWELL clocks per slot and the
  // slot advances until the last slot, then blank starts. In blank, tick
  // counts BLANK clocks, then the next column starts at slot 0.
  always_comb begin
    state_n = state;
    col_n   = col;
    slot_n  = slot;
    tick_n  = tick;
    if (!started) begin
      state_n = S_DRIVE;
      col_n   = '0;
      slot_n  = '0;
      tick_n  = '0;
    end else begin
      case (state)
        S_DRIVE: begin
          if (tick == DWELL_LAST) begin
            tick_n = '0;
            if (slot == SLOT_LAST) begin
              state_n = S_BLANK;
            end else begin
              slot_n = slot + 1'b1;
            end
          end else begin
            tick_n = tick + 1'b1;
          end
        end
        S_BLANK: begin
          if (tick == BLANK_LAST) begin
            state_n = S_DRIVE;
            tick_n  = '0;
            slot_n  = '0;
            col_n   = (col == COL_LAST) ? '0 : col + 1'b1;
          end else begin
            tick_n = tick + 1'b1;
          end
        end
        default: begin
          state_n = S_DRIVE;
        end
      endcase
    end
  end

  // Drive pattern for the position being entered. It uses the buffer that
  // will be displayed after this edge, so column 0 of a swapped frame
  // shows the new pixels from its very first slot.
  always_comb begin
    int   base;
    logic lit;
    base      = 0;
    lit       = 1'b0;
    row_n     = ROWS_OFF;
    col_sel_n = COLS_OFF;
    if (state_n == S_DRIVE) begin
      for (int r = 0; r < ROWS; r++) begin
        base     = (int'(col_n) * ROWS + r) * BPP;
        lit      = active_n[base +: BPP] > slot_n;
        row_n[r] = ROW_ACTIVE_HIGH ? lit : ~lit;
      end
      for (int c = 0; c < COLS; c++) begin
        col_sel_n[c] = (col_n == COL_W'(c)) ^ COL_ACTIVE_LOW;
      end
    end
  end

  // Registered line drives; reset forces every line inactive at once so an
  // aborted scan leaves no partial column lit.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_out <= ROWS_OFF;
      col_out <= COLS_OFF;
    end else begin
      row_out <= row_n;
      col_out <= col_sel_n;
    end
  end

  // Frame buffers. A write always lands in the pending buffer and keeps
  // 'pending' set, even on the swap cycle: the displayed buffer takes the
  // old pending contents and the new write waits for the next frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      active    <= '0;
      pend      <= '0;
      pending_q <= 1'b0;
    end else begin
      active <= active_n;
      if (frame_wr) begin
        pend      <= frame_data;
        pending_q <= 1'b1;
      end else if (do_swap) begin
        pending_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ledmatrix_pwm_scan.md
Name: ledmatrix_pwm_scan

Overview:
- Parametrised multiplexed LED-matrix scanner: successor to the fixed 8x8 1-bit column scanner.
- Adds configurable geometry, per-pixel grayscale via PWM slots, and configurable dwell and blanking times.
- Adds a double-buffered frame store that swaps only at frame boundaries, so the display never tears.
- Sits between a frame producer (pattern or video logic) and the PMOD pin mapping / tristate layer; its outputs are logical row/column drives, not pin-ordered.

Parameters:
- ROWS, 8, number of row lines (data lines, driven per column).
- COLS, 8, number of column lines (scanned one at a time).
- BPP, 4, bits per pixel intensity; SLOTS = 2^BPP - 1 PWM slots per column.
- DWELL, 1, clk cycles per PWM slot (>=1).
- BLANK, 1, clk cycles of all-off between columns (>=1).
- COL_ACTIVE_LOW, 1, 1: selected column driven 0 and others 1; 0: inverted.
- ROW_ACTIVE_HIGH, 1, 1: lit row driven 1; 0: inverted.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- frame_data  in  ROWS*COLS*BPP  new frame; pixel (c,r) at bits [(c*ROWS+r)*BPP +: BPP].
- frame_wr  in  1  one-cycle strobe: capture frame_data into pending buffer.
- row_out  out  ROWS  registered row drive.
- col_out  out  COLS  registered column select drive.
- col_idx  out  clog2(COLS) (min 1)  column currently scanned.
- frame_start  out  1  one-cycle pulse when column 0 slot 0 is first driven in a frame.
- swapped  out  1  one-cycle pulse on the cycle the active buffer took pending data.
- pending  out  1  pending buffer holds a frame not yet displayed.

Behaviour:
- Two storage registers: active (displayed) and pend (pending), each ROWS*COLS*BPP bits.
- Reset: active=0, pend=0, pending=0, swapped=0, frame_start=0, col_idx=0. row_out and col_out at inactive levels: rows all 0 and cols all 1 for default polarity.
- Reset mid-frame aborts the scan immediately; there are no partial-column artefacts afterwards.
- Scan FSM states: DRIVE and BLANK. Counters: col (0..COLS-1), slot (0..SLOTS-1), tick (0..DWELL-1 in DRIVE, 0..BLANK-1 in BLANK).
- First clk edge after rst deasserts enters DRIVE with col=0, slot=0, tick=0; frame_start=1 for that cycle.
- DRIVE outputs (registered, visible the cycle after the counter state is entered):
  - col_out selects col only.
  - row_out bit r is lit iff active pixel(col,r) > slot (unsigned).
  - Value 0 is never lit; value 2^BPP-1 is lit in all SLOTS slots.
- DRIVE timing: tick increments each cycle. At tick=DWELL-1, slot increments. At slot=SLOTS-1 and tick=DWELL-1, go to BLANK with tick=0.
- BLANK: all rows and columns inactive for exactly BLANK cycles, then DRIVE with col+1 and slot=0. col wraps from COLS-1 to 0.
- Column period = SLOTS*DWELL + BLANK cycles; frame period = COLS × column period.
- Frame end is the last BLANK cycle of col COLS-1. On that cycle, if pending=1: active<=pend, pending<=0, swapped=1. The next DRIVE cycle (col 0) asserts frame_start.
- frame_wr (any cycle, not in rst): pend<=frame_data, pending<=1. A later write before the swap overwrites pend (latest wins).
- frame_wr on the frame-end cycle: active takes the old pend contents; pend takes the new data; pending remains 1. The new frame displays one frame later.
- frame_wr is ignored while rst is high.
- col_idx reflects the column whose drive is currently on the outputs; it holds during BLANK.
- Width rules: slot compare is BPP-bit unsigned. Counter widths use clog2 with a minimum of 1. COLS=1 and ROWS=1 must work.

Test Plan:
- Reset values (ROWS=COLS=8, BPP=2, DWELL=1, BLANK=1; SLOTS=3, column period 4, frame 32): hold rst 3 cycles -> rows=0x00, cols=0xFF, pending=0. First frame_start exactly 1 cycle after rst falls, then every 32 cycles.
- PWM levels: write pixels (0,0..3) = 0,1,2,3, then wait for swap. Column 0 row_out over slots 0/1/2 = 0b1110, 0b1100, 0b1000 (bits 3..0). cols=0xFE during those slots, then 1 blank cycle with rows=0x00 and cols=0xFF.
- Double buffer: frame_wr A mid-frame -> active unchanged until frame end. swapped pulses on the last blank of col 7; the next frame shows A; pending drops to 0.
- Overwrite and collision: write A, then B in the same frame -> B displayed. Write C exactly on the frame-end cycle while B is pending -> B shown, pending=1, C shown the following frame.
- Timing and polarity variant: DWELL=3, BLANK=2, COL_ACTIVE_LOW=0, ROW_ACTIVE_HIGH=0. Column period = 11 cycles; selected col drives 1; lit rows drive 0; blank drives cols 0 and rows 1.
- Reset mid-frame: assert rst during col 5 slot 1 -> outputs inactive the next cycle and active=0. After release, scan restarts at col 0 with frame_start.
